// File: rtl/lsu_mem_master_pkg.sv
// Shared types for the MEM-stage load/store initiator: memory width codes,
// read/write strobe encoding, fault causes and the request state machine.
package lsu_mem_master_pkg;

   typedef enum logic [2:0] {
      WID_B   = 3'b000,
      WID_H   = 3'b001,
      WID_W   = 3'b010,
      WID_D   = 3'b011,
      WID_BU  = 3'b100,
      WID_HU  = 3'b101,
      WID_WU  = 3'b110,
      WID_ILL = 3'b111
   } mem_wid_e;

   localparam logic MEM_WRITE = 1'b0;
   localparam logic MEM_READ  = 1'b1;

   typedef enum logic [1:0] {
      NONE        = 2'd0,
      LD_MISALIGN = 2'd1,
      ST_MISALIGN = 2'd2,
      ILL_WIDTH   = 2'd3
   } lsu_cause_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_align_check.sv
// Width legality and natural-alignment check for a load/store request.
// Purely combinational; an illegal width outranks any misalignment.
module lsu_align_check
   import lsu_mem_master_pkg::*;
(
   input  logic       we,
   input  logic [2:0] wid,
   input  logic [2:0] addr,
   output logic       fault,
   output lsu_cause_e cause
);

   logic misalign_s;
   logic illegal_s;

   // Classify the request: unsigned widths are load-only
   always_comb begin
      misalign_s = 1'b0;
      illegal_s  = (wid == WID_ILL) || (we && wid[2]);
      case (mem_wid_e'(wid))
         WID_B, WID_BU: misalign_s = 1'b0;
         WID_H, WID_HU: misalign_s = addr[0];
         WID_W, WID_WU: misalign_s = (addr[1:0] != 2'b00);
         WID_D:         misalign_s = (addr != 3'b000);
         default:       misalign_s = 1'b0;
      endcase
      if (illegal_s) begin
         fault = 1'b1;
         cause = ILL_WIDTH;
      end else if (misalign_s) begin
         fault = 1'b1;
         if (we) begin
            cause = ST_MISALIGN;
         end else begin
            cause = LD_MISALIGN;
         end
      end else begin
         fault = 1'b0;
         cause = NONE;
      end
   end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: accepts one request, issues a single-cycle
// memory access, waits the fixed read latency and returns data or a fault.
module lsu_mem_master
   import lsu_mem_master_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_wid_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_fault_o,
   output logic [1:0]            resp_cause_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic                  mem_enwr_o,
   output logic                  mem_en_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic [2:0]            mem_wid_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [2:0] LAT_CNT = 3'(MEM_LATENCY);

   lsu_state_e            state_r;
   lsu_state_e            state_nxt_s;
   logic                  enwr_r;
   logic [2:0]            wid_r;
   logic [DATA_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic                  fault_r;
   lsu_cause_e            cause_r;
   logic [2:0]            cnt_r;

   logic                  chk_fault_s;
   lsu_cause_e            chk_cause_s;
   logic                  req_ready_s;
   logic                  accept_s;
   logic                  mem_en_s;

   lsu_align_check u_align_check (
      .we    (req_we_i),
      .wid   (req_wid_i),
      .addr  (req_addr_i[2:0]),
      .fault (chk_fault_s),
      .cause (chk_cause_s)
   );

   // Next-state, request acceptance and memory-enable decode
   always_comb begin
      state_nxt_s = state_r;
      req_ready_s = 1'b0;
      accept_s    = 1'b0;
      mem_en_s    = 1'b0;
      case (state_r)
         IDLE: begin
            req_ready_s = rst_n && !flush_i;
            accept_s    = req_ready_s && req_valid_i;
            if (accept_s) begin
               state_nxt_s = chk_fault_s ? RESP : ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            mem_en_s = rst_n && !flush_i;
            if (flush_i) begin
               state_nxt_s = IDLE;
            end else if (enwr_r == MEM_WRITE) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         WAIT: begin
            if (flush_i) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == 3'd1) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            if (flush_i || resp_ready_i) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Request capture, latency countdown and read-data capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enwr_r  <= MEM_READ;
         wid_r   <= 3'b000;
         addr_r  <= '0;
         wdata_r <= '0;
         rdata_r <= '0;
         fault_r <= 1'b0;
         cause_r <= NONE;
         cnt_r   <= 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  enwr_r  <= !req_we_i;
                  wid_r   <= req_wid_i;
                  addr_r  <= req_addr_i;
                  wdata_r <= req_wdata_i;
                  rdata_r <= '0;
                  fault_r <= chk_fault_s;
                  cause_r <= chk_cause_s;
               end
            end
            ISSUE: cnt_r <= LAT_CNT;
            WAIT: begin
               cnt_r <= cnt_r - 3'd1;
               // Only the final latency cycle carries valid read data
               if ((cnt_r == 3'd1) && !flush_i) begin
                  rdata_r <= mem_rdata_i;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_s;
   assign resp_valid_o = (state_r == RESP);
   assign resp_rdata_o = rdata_r;
   assign resp_fault_o = fault_r;
   assign resp_cause_o = cause_r;
   assign mem_addr_o   = addr_r;
   assign mem_enwr_o   = enwr_r;
   assign mem_en_o     = mem_en_s;
   assign mem_data_o   = wdata_r;
   assign mem_wid_o    = wid_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: two instances (read latency 1 and 3) driven with
// directed and random requests, checked against a spec-level reference model.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n      [2];
   logic        flush      [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [2:0]  req_wid    [2];
   logic [63:0] req_addr   [2];
   logic [63:0] req_wdata  [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [63:0] resp_rdata [2];
   logic        resp_fault [2];
   logic [1:0]  resp_cause [2];
   logic [63:0] mem_addr   [2];
   logic        mem_enwr   [2];
   logic        mem_en     [2];
   logic [63:0] mem_data   [2];
   logic [2:0]  mem_wid    [2];
   logic [63:0] mem_rdata  [2];

   int pass_cnt = 0;
   int total_cnt = 0;

   lsu_mem_master #(.DATA_WIDTH(64), .MEM_LATENCY(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n[0]), .flush_i(flush[0]),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
      .req_wid_i(req_wid[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
      .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]), .resp_rdata_o(resp_rdata[0]),
      .resp_fault_o(resp_fault[0]), .resp_cause_o(resp_cause[0]),
      .mem_addr_o(mem_addr[0]), .mem_enwr_o(mem_enwr[0]), .mem_en_o(mem_en[0]),
      .mem_data_o(mem_data[0]), .mem_wid_o(mem_wid[0]), .mem_rdata_i(mem_rdata[0])
   );

   lsu_mem_master #(.DATA_WIDTH(64), .MEM_LATENCY(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n[1]), .flush_i(flush[1]),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
      .req_wid_i(req_wid[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
      .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]), .resp_rdata_o(resp_rdata[1]),
      .resp_fault_o(resp_fault[1]), .resp_cause_o(resp_cause[1]),
      .mem_addr_o(mem_addr[1]), .mem_enwr_o(mem_enwr[1]), .mem_en_o(mem_en[1]),
      .mem_data_o(mem_data[1]), .mem_wid_o(mem_wid[1]), .mem_rdata_i(mem_rdata[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Memory model: counts enables, records the issued access, and presents the
   // chosen read value only in the cycle exactly lat_of(d) cycles after enable.
   int          age       [2] = '{100, 100};
   int          en_cnt    [2] = '{0, 0};
   logic [63:0] next_good [2];
   logic [63:0] good      [2];
   logic [63:0] en_addr   [2];
   logic [63:0] en_data   [2];
   logic [2:0]  en_wid    [2];
   logic        en_enwr   [2];

   always begin
      @(negedge clk);
      #2;
      for (int m = 0; m < 2; m++) begin
         if (mem_en[m] === 1'b1) begin
            en_cnt[m]++;
            en_addr[m] = mem_addr[m];
            en_data[m] = mem_data[m];
            en_wid[m]  = mem_wid[m];
            en_enwr[m] = mem_enwr[m];
            if (mem_enwr[m] === 1'b1) begin
               age[m]  = 0;
               good[m] = next_good[m];
            end
         end else if (age[m] < 100) begin
            age[m]++;
         end
         mem_rdata[m] = (age[m] == lat_of(m)) ? good[m] : {$urandom(), $urandom()};
      end
   end

   // One transaction: reference model predicts fault/cause/data/latency, then
   // the response is held for 'hold' extra cycles before the handshake.
   task automatic do_req(input int d, input logic we, input logic [2:0] wid,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] mdata, input int hold);
      int          size, exp_lat, lat, en0;
      logic        ill, mis, exp_fault;
      logic [1:0]  exp_cause;
      logic [63:0] exp_rdata;
      size      = 1 << int'(wid[1:0]);
      ill       = (wid == 3'd7) || (we && wid[2]);
      mis       = (addr % 64'(size)) != 64'd0;
      exp_cause = ill ? 2'd3 : (mis ? (we ? 2'd2 : 2'd1) : 2'd0);
      exp_fault = (exp_cause != 2'd0);
      exp_rdata = (exp_fault || we) ? 64'd0 : mdata;
      exp_lat   = exp_fault ? 1 : (we ? 2 : lat_of(d) + 2);
      next_good[d] = mdata;
      en0 = en_cnt[d];
      @(negedge clk);
      total_cnt++; if (req_ready[d] !== 1'b1) $display("FAIL idle_ready d%0d: got %b exp 1", d, req_ready[d]); else pass_cnt++;
      req_valid[d] = 1'b1; req_we[d] = we; req_wid[d] = wid; req_addr[d] = addr; req_wdata[d] = wdata;
      lat = 0;
      do begin
         @(negedge clk);
         req_valid[d] = 1'b0;
         lat++;
      end while (resp_valid[d] !== 1'b1 && lat < 20);
      total_cnt++; if (lat !== exp_lat) $display("FAIL latency d%0d wid%0d we%0b: got %0d exp %0d", d, wid, we, lat, exp_lat); else pass_cnt++;
      total_cnt++; if (resp_fault[d] !== exp_fault) $display("FAIL fault d%0d: got %b exp %b", d, resp_fault[d], exp_fault); else pass_cnt++;
      total_cnt++; if (resp_cause[d] !== exp_cause) $display("FAIL cause d%0d: got %0d exp %0d", d, resp_cause[d], exp_cause); else pass_cnt++;
      total_cnt++; if (resp_rdata[d] !== exp_rdata) $display("FAIL rdata d%0d: got %h exp %h", d, resp_rdata[d], exp_rdata); else pass_cnt++;
      total_cnt++; if (en_cnt[d] - en0 !== (exp_fault ? 0 : 1)) $display("FAIL en_pulses d%0d: got %0d exp %0d", d, en_cnt[d] - en0, exp_fault ? 0 : 1); else pass_cnt++;
      if (!exp_fault) begin
         total_cnt++; if (en_addr[d] !== addr) $display("FAIL mem_addr d%0d: got %h exp %h", d, en_addr[d], addr); else pass_cnt++;
         total_cnt++; if (en_wid[d] !== wid) $display("FAIL mem_wid d%0d: got %0d exp %0d", d, en_wid[d], wid); else pass_cnt++;
         total_cnt++; if (en_enwr[d] !== ~we) $display("FAIL mem_enwr d%0d: got %b exp %b", d, en_enwr[d], ~we); else pass_cnt++;
         if (we) begin
            total_cnt++; if (en_data[d] !== wdata) $display("FAIL mem_data d%0d: got %h exp %h", d, en_data[d], wdata); else pass_cnt++;
         end
      end
      // A competing request is offered while the response is stalled
      req_valid[d] = (hold > 0); req_we[d] = 1'b0; req_wid[d] = 3'd0; req_addr[d] = {$urandom(), $urandom()};
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         total_cnt++; if (resp_valid[d] !== 1'b1) $display("FAIL hold_valid d%0d c%0d: got %b exp 1", d, h, resp_valid[d]); else pass_cnt++;
         total_cnt++; if (resp_rdata[d] !== exp_rdata) $display("FAIL hold_rdata d%0d c%0d: got %h exp %h", d, h, resp_rdata[d], exp_rdata); else pass_cnt++;
         total_cnt++; if (req_ready[d] !== 1'b0) $display("FAIL hold_ready d%0d c%0d: got %b exp 0", d, h, req_ready[d]); else pass_cnt++;
      end
      req_valid[d] = 1'b0;
      resp_ready[d] = 1'b1;
      @(negedge clk);
      resp_ready[d] = 1'b0;
      total_cnt++; if (resp_valid[d] !== 1'b0) $display("FAIL post_hs_valid d%0d: got %b exp 0", d, resp_valid[d]); else pass_cnt++;
      total_cnt++; if (req_ready[d] !== 1'b1) $display("FAIL post_hs_ready d%0d: got %b exp 1", d, req_ready[d]); else pass_cnt++;
      total_cnt++; if (en_cnt[d] - en0 !== (exp_fault ? 0 : 1)) $display("FAIL extra_en d%0d: got %0d exp %0d", d, en_cnt[d] - en0, exp_fault ? 0 : 1); else pass_cnt++;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; flush[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
         req_wid[d] = 3'd0; req_addr[d] = 64'd0; req_wdata[d] = 64'd0; resp_ready[d] = 1'b0;
         next_good[d] = 64'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total_cnt++; if (req_ready[d] !== 1'b0) $display("FAIL rst_ready d%0d: got %b exp 0", d, req_ready[d]); else pass_cnt++;
         total_cnt++; if (resp_valid[d] !== 1'b0) $display("FAIL rst_valid d%0d: got %b exp 0", d, resp_valid[d]); else pass_cnt++;
         total_cnt++; if (mem_en[d] !== 1'b0) $display("FAIL rst_en d%0d: got %b exp 0", d, mem_en[d]); else pass_cnt++;
         total_cnt++; if (mem_enwr[d] !== 1'b1) $display("FAIL rst_enwr d%0d: got %b exp 1", d, mem_enwr[d]); else pass_cnt++;
         total_cnt++; if (mem_addr[d] !== 64'd0) $display("FAIL rst_addr d%0d: got %h exp 0", d, mem_addr[d]); else pass_cnt++;
         total_cnt++; if (mem_data[d] !== 64'd0) $display("FAIL rst_data d%0d: got %h exp 0", d, mem_data[d]); else pass_cnt++;
         total_cnt++; if (mem_wid[d] !== 3'd0) $display("FAIL rst_wid d%0d: got %0d exp 0", d, mem_wid[d]); else pass_cnt++;
         total_cnt++; if ({resp_rdata[d], resp_fault[d], resp_cause[d]} !== 67'd0) $display("FAIL rst_resp d%0d: got %h/%b/%0d exp 0", d, resp_rdata[d], resp_fault[d], resp_cause[d]); else pass_cnt++;
         rst_n[d] = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total_cnt++; if (req_ready[d] !== 1'b1) $display("FAIL rel_ready d%0d: got %b exp 1", d, req_ready[d]); else pass_cnt++;
      end
   endtask

   task automatic test_directed();
      do_req(0, 1'b0, 3'd3, 64'h1000, 64'h0, 64'hDEADBEEF_01234567, 0);
      do_req(0, 1'b1, 3'd2, 64'h2004, 64'hCAFEBABE, 64'h1111, 0);
      do_req(0, 1'b0, 3'd1, 64'h3001, 64'h0, 64'h2222, 0);
      do_req(0, 1'b1, 3'd3, 64'h3004, 64'h5555, 64'h3333, 0);
      do_req(0, 1'b1, 3'd4, 64'h3000, 64'h6666, 64'h4444, 0);
      do_req(0, 1'b0, 3'd7, 64'h3000, 64'h0, 64'h7777, 0);
      do_req(0, 1'b0, 3'd6, 64'h3002, 64'h0, 64'h8888, 0);
   endtask

   task automatic test_backpressure();
      do_req(0, 1'b0, 3'd2, 64'h40, 64'h0, {$urandom(), $urandom()}, 5);
      do_req(1, 1'b1, 3'd1, 64'h42, {$urandom(), $urandom()}, 64'h0, 3);
   endtask

   task automatic test_latency3();
      do_req(1, 1'b0, 3'd0, 64'h7, 64'h0, 64'hA5A5_0000_1234_5678, 0);
      do_req(1, 1'b0, 3'd3, 64'h88, 64'h0, {$urandom(), $urandom()}, 1);
   endtask

   task automatic test_flush();
      int en0;
      // Store flushed while in ISSUE
      en0 = en_cnt[0];
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wid[0] = 3'd3; req_addr[0] = 64'h500; req_wdata[0] = 64'h99;
      @(negedge clk);
      req_valid[0] = 1'b0; flush[0] = 1'b1;
      #1;
      total_cnt++; if (mem_en[0] !== 1'b0) $display("FAIL flush_issue_en: got %b exp 0", mem_en[0]); else pass_cnt++;
      total_cnt++; if (req_ready[0] !== 1'b0) $display("FAIL flush_blocks_ready: got %b exp 0", req_ready[0]); else pass_cnt++;
      @(negedge clk);
      flush[0] = 1'b0;
      #1;
      total_cnt++; if (req_ready[0] !== 1'b1) $display("FAIL flush_issue_ready: got %b exp 1", req_ready[0]); else pass_cnt++;
      repeat (3) begin
         @(negedge clk);
         total_cnt++; if (resp_valid[0] !== 1'b0) $display("FAIL flush_issue_resp: got %b exp 0", resp_valid[0]); else pass_cnt++;
      end
      total_cnt++; if (en_cnt[0] !== en0) $display("FAIL flush_issue_pulses: got %0d exp %0d", en_cnt[0] - en0, 0); else pass_cnt++;
      // Load flushed during WAIT on the latency-3 instance
      next_good[1] = 64'hBAD0;
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_wid[1] = 3'd2; req_addr[1] = 64'h600;
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      flush[1] = 1'b1;
      @(negedge clk);
      flush[1] = 1'b0;
      #1;
      total_cnt++; if (resp_valid[1] !== 1'b0) $display("FAIL flush_wait_resp: got %b exp 0", resp_valid[1]); else pass_cnt++;
      total_cnt++; if (req_ready[1] !== 1'b1) $display("FAIL flush_wait_ready: got %b exp 1", req_ready[1]); else pass_cnt++;
      repeat (4) begin
         @(negedge clk);
         total_cnt++; if (resp_valid[1] !== 1'b0) $display("FAIL flush_wait_late: got %b exp 0", resp_valid[1]); else pass_cnt++;
      end
      // Faulting response dropped by a flush in RESP
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_wid[0] = 3'd1; req_addr[0] = 64'h1;
      @(negedge clk);
      req_valid[0] = 1'b0;
      total_cnt++; if (resp_valid[0] !== 1'b1) $display("FAIL flush_resp_pre: got %b exp 1", resp_valid[0]); else pass_cnt++;
      flush[0] = 1'b1;
      @(negedge clk);
      flush[0] = 1'b0;
      #1;
      total_cnt++; if (resp_valid[0] !== 1'b0) $display("FAIL flush_resp_drop: got %b exp 0", resp_valid[0]); else pass_cnt++;
      total_cnt++; if (req_ready[0] !== 1'b1) $display("FAIL flush_resp_ready: got %b exp 1", req_ready[0]); else pass_cnt++;
   endtask

   task automatic test_reset_mid_wait();
      next_good[1] = 64'hFEED;
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_wid[1] = 3'd0; req_addr[1] = 64'h7;
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b0;
      @(negedge clk);
      total_cnt++; if (resp_valid[1] !== 1'b0) $display("FAIL midrst_valid: got %b exp 0", resp_valid[1]); else pass_cnt++;
      total_cnt++; if (mem_en[1] !== 1'b0) $display("FAIL midrst_en: got %b exp 0", mem_en[1]); else pass_cnt++;
      total_cnt++; if (req_ready[1] !== 1'b0) $display("FAIL midrst_ready: got %b exp 0", req_ready[1]); else pass_cnt++;
      total_cnt++; if ({mem_addr[1], mem_enwr[1]} !== 65'd1) $display("FAIL midrst_mem: got %h/%b exp 0/1", mem_addr[1], mem_enwr[1]); else pass_cnt++;
      rst_n[1] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         total_cnt++; if (resp_valid[1] !== 1'b0) $display("FAIL midrst_late: got %b exp 0", resp_valid[1]); else pass_cnt++;
      end
      total_cnt++; if (req_ready[1] !== 1'b1) $display("FAIL midrst_ready_after: got %b exp 1", req_ready[1]); else pass_cnt++;
      do_req(1, 1'b0, 3'd5, 64'h10, 64'h0, {$urandom(), $urandom()}, 0);
   endtask

   task automatic test_random();
      logic [63:0] addr;
      for (int i = 0; i < 60; i++) begin
         addr = {$urandom(), $urandom()};
         if ($urandom_range(0, 1) == 1) addr[2:0] = 3'd0;
         do_req(i % 2, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr,
                {$urandom(), $urandom()}, {$urandom(), $urandom()}, $urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_latency3();
      test_flush();
      test_reset_mid_wait();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator in the MEM stage; the requesting end of the data-memory interface.
- Accepts one load or store per transaction from the pipeline over a valid/ready handshake.
- Checks width legality and natural alignment; faulting requests never touch memory.
- Legal requests drive the memory's addr/enwr/en/data/wid port for exactly one cycle. It waits the fixed memory read latency, then returns data or a fault over a valid/ready response handshake.

Parameters:
- DATA_WIDTH, 64: address and data width.
- MEM_LATENCY, 1: cycles from the memory-enable edge to read data valid; range 1..7.

Ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- flush_i  in  1  pipeline flush; kills any in-flight op.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_wid_i  in  3  width code (B/H/W/D/BU/HU/WU).
- req_addr_i  in  DATA_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, low-aligned.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- resp_rdata_o  out  DATA_WIDTH  load data, already extended by memory; 0 for stores and faults.
- resp_fault_o  out  1  fault flag.
- resp_cause_o  out  2  0 none, 1 load misaligned, 2 store misaligned, 3 illegal width.
- mem_addr_o  out  DATA_WIDTH  memory address.
- mem_enwr_o  out  1  0 = Write, 1 = Read.
- mem_en_o  out  1  memory enable.
- mem_data_o  out  DATA_WIDTH  memory write data.
- mem_wid_o  out  3  memory width code.
- mem_rdata_i  in  DATA_WIDTH  memory read data.

Behaviour:
- Width codes: B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110; 111 is illegal.
- Stores accept B/H/W/D only. BU/HU/WU/111 on a store gives cause 3.
- Alignment: H/HU need addr[0]=0; W/WU need addr[1:0]=0; D needs addr[2:0]=0; B/BU are always aligned.
- Width check has priority over alignment check.
- Reset (rst_n=0 sampled at posedge):
  - state=IDLE; all registered outputs 0; mem_enwr_o=1 (Read).
  - req_ready_o=0 while rst_n=0.
- State machine:
  - IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, register we/wid/addr/wdata and evaluate checks. Fault → RESP with fault set. Otherwise → ISSUE.
  - ISSUE (1 cycle): mem_en_o = !flush_i; mem_enwr_o = !we; mem_addr/data/wid come from the registers. Store → RESP. Load → WAIT with cnt=MEM_LATENCY.
  - WAIT: cnt decrements each cycle. In the cycle cnt==1, capture mem_rdata_i into the rdata register → RESP.
  - RESP: resp_valid_o=1 with rdata/fault/cause held stable until resp_ready_i; on the handshake → IDLE.
- No accept in RESP; a new request is accepted no earlier than the cycle after the response handshake.
- Latency, MEM_LATENCY=1, request accepted at edge t:
  - ISSUE in cycle t+1.
  - Load: capture in t+2, resp_valid_o from t+3.
  - Store: resp_valid_o from t+2.
  - Fault: resp_valid_o from t+1.
- mem_en_o is high only in ISSUE. mem_addr/data/wid/enwr hold their registered values in every state, so they are stable around the enable edge. After reset they hold 0, with enwr=Read.
- flush_i:
  - In IDLE: blocks acceptance (req_ready_o=0).
  - In ISSUE: suppresses mem_en_o and returns to IDLE.
  - In WAIT or RESP: drops the response, returns to IDLE, resp_valid_o=0 next cycle.
- resp_valid_o never deasserts without a handshake except on flush or reset.
- Reset mid-operation aborts any state; a pending memory read result is ignored.

Decomposition:
- utils_pkg additions:
  - mem_wid_e enum with the codes above.
  - MEM_WRITE=1'b0, MEM_READ=1'b1.
  - lsu_cause_e enum (NONE, LD_MISALIGN, ST_MISALIGN, ILL_WIDTH).
  - lsu_state_e (IDLE, ISSUE, WAIT, RESP).
- One combinational sub-module, lsu_align_check (inputs we, wid, addr[2:0]; outputs fault, cause), reusable by fetch/AMO paths later.

Test Plan:
- Reset, then load D addr 0x1000 with memory returning 0xDEADBEEF_01234567 one cycle after en → mem_en_o pulses once with enwr=1 and wid=011; resp_valid_o at t+3 with that rdata; fault=0.
- Store W addr 0x2004, data 0xCAFEBABE → one-cycle mem_en_o with enwr=0, addr=0x2004, data=0xCAFEBABE; resp_valid_o at t+2, rdata=0.
- Load H at 0x3001 → no mem_en_o ever; resp at t+1 with fault=1, cause=1. Store D at 0x3004 → cause=2. Store BU at 0x3000 → cause=3 (not 2).
- Load W at 0x40, resp_ready_i held low 5 cycles → resp_valid_o and rdata stable all 5 cycles; req_ready_o=0; the next request is accepted only after the handshake.
- flush_i in ISSUE of a store → mem_en_o stays 0, no response. flush_i in WAIT of a load → no response; req_ready_o=1 the following cycle.
- MEM_LATENCY=3, load B at 0x7 with memory data valid only on the 3rd cycle after en → the captured value equals the 3rd-cycle data, not earlier garbage. rst_n pulled low mid-WAIT → IDLE, resp_valid_o=0, mem_en_o=0.
